pwm_bank: RTL and testbench
===========================

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of PWM outputs, 1..16.
REQ-002 Parameter WIDTH, default 16: period, duty and counter width.
REQ-003 Parameter INVERT, default all-zero CHANNELS-bit mask: set bit inverts that channel's output.
REQ-004 SYSCLK  in  1  fabric clock, all logic on rising edge.
REQ-005 NSYSRESET  in  1  reset, asynchronous, active-low.
REQ-006 wr_en  in  1  register write strobe, one write per asserted cycle.
REQ-007 wr_addr  in  8  write register address.
REQ-008 wr_data  in  WIDTH  write data.
REQ-009 rd_addr  in  8  read register address.
REQ-010 rd_data  out  WIDTH  read data, registered.
REQ-011 pwm_out  out  CHANNELS  PWM outputs, bit n = channel n.
REQ-012 period_tick  out  1  one-cycle pulse on every period wrap.

Function
REQ-013 Register map: 0x00 CTRL (bit0 enable), 0x01 PERIOD, 0x02 PRESCALE (low 8 bits used), 0x10+n DUTY[n] for n<CHANNELS; other addresses: writes ignored, reads return 0.
REQ-014 rd_data shall present the staged value at rd_addr one cycle after rd_addr is sampled.
REQ-015 Writes to PERIOD/DUTY land in staged registers; active copies load from staged only at period wrap or while disabled.
REQ-016 Prescaler counts 0..PRESCALE; tick asserted on the cycle it equals PRESCALE, then it returns to 0 (PRESCALE=0 gives a tick every cycle).
REQ-017 Counter advances on tick; on tick with counter == active PERIOD it wraps to 0, loads active registers, and asserts period_tick the same cycle.
REQ-018 Raw output n = (counter < active DUTY[n]); pwm_out[n] = raw XOR INVERT[n].
REQ-019 Boundaries: DUTY=0 always inactive; DUTY > PERIOD always active; PERIOD=0 wraps every tick, output active iff DUTY>0.
REQ-020 Write and wrap in the same cycle: wrap loads the pre-write staged value; the new value takes effect at the next wrap.
REQ-021 Enable low: prescaler and counter held at 0, period_tick low, pwm_out = INVERT, active registers track staged every cycle.
REQ-022 Enable rising: counting starts from 0 on the next cycle with the current staged values.

Reset
REQ-023 NSYSRESET low shall asynchronously clear CTRL, PERIOD, PRESCALE, all DUTY (staged and active), counter, prescaler, rd_data and period_tick.
REQ-024 During and after reset until enabled, pwm_out = INVERT.
REQ-025 Reset asserted mid-period shall abort the period immediately, with no completion of the current pulse.

Configuration
REQ-026 Macro PWM_BANK_RAMP_EN defined: adds register 0x03 RAMP_STEP (reset 0); at each wrap, active DUTY[n] moves toward staged DUTY[n] by at most RAMP_STEP, landing exactly on target; RAMP_STEP=0 loads directly.
REQ-027 Macro PWM_BANK_RAMP_EN undefined: address 0x03 unmapped, active DUTY loads staged directly at wrap.
REQ-028 While disabled, ramp is bypassed and active tracks staged directly, in either build.

Verification
REQ-029 PERIOD=9, PRESCALE=0, DUTY0=3, enable -> pwm_out[0] high 3 / low 7 cycles, period_tick every 10 cycles.
REQ-030 DUTY0=0 and DUTY1=12 with PERIOD=9 -> ch0 constant low, ch1 constant high; INVERT=0b0001 -> ch0 constant high.
REQ-031 Write DUTY0=7 mid-period and on the wrap cycle -> mid-period write applies at the next wrap; wrap-cycle write applies one period later.
REQ-032 PRESCALE=3, PERIOD=4 -> period_tick every 20 cycles; write 0x55 to address 0x40 -> no effect, rd_data=0.
REQ-033 Assert NSYSRESET for a partial cycle mid-pulse -> outputs go to INVERT immediately, all reads return 0.
REQ-034 RAMP_EN build, RAMP_STEP=2, DUTY0 0->7 -> active duty 2,4,6,7 over four consecutive periods.

Source files
------------

// File: rtl/pwm_bank.sv
// pwm_bank: CHANNELS PWM outputs with staged/active period and duty registers and a shared prescaler.
// Defining PWM_BANK_RAMP_EN adds RAMP_STEP (0x03) so active duties slew toward their targets at each wrap.
module pwm_bank #(
    parameter int                  CHANNELS = 4,
    parameter int                  WIDTH    = 16,
    parameter logic [CHANNELS-1:0] INVERT   = '0
) (
    input  logic                SYSCLK,
    input  logic                NSYSRESET,
    input  logic                wr_en,
    input  logic [7:0]          wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [7:0]          rd_addr,
    output logic [WIDTH-1:0]    rd_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_PERIOD   = 8'h01;
    localparam logic [7:0] ADDR_PRESCALE = 8'h02;
    localparam logic [7:0] ADDR_DUTY     = 8'h10;
`ifdef PWM_BANK_RAMP_EN
    localparam logic [7:0] ADDR_RAMP     = 8'h03;
`endif

    logic                               enable_q, enable_d;
    logic [WIDTH-1:0]                   period_stg_q, period_stg_d;
    logic [WIDTH-1:0]                   period_act_q, period_act_d;
    logic [7:0]                         prescale_q, prescale_d;
    logic [7:0]                         pre_q, pre_d;
    logic [WIDTH-1:0]                   cnt_q, cnt_d;
    logic [WIDTH-1:0]                   rd_data_q, rd_data_d;
    logic [CHANNELS-1:0][WIDTH-1:0]     duty_stg_q, duty_stg_d;
    logic [CHANNELS-1:0][WIDTH-1:0]     duty_act_q, duty_act_d;
`ifdef PWM_BANK_RAMP_EN
    logic [WIDTH-1:0]                   ramp_step_q, ramp_step_d;

    // Move at most 'step' toward the target, never overshooting; a zero step jumps straight there.
    function automatic logic [WIDTH-1:0] rampToward(input logic [WIDTH-1:0] cur,
                                                    input logic [WIDTH-1:0] tgt,
                                                    input logic [WIDTH-1:0] step);
        logic [WIDTH-1:0] res;
        res = tgt;
        if (step != '0) begin
            if ((cur < tgt) && ((tgt - cur) > step)) begin
                res = cur + step;
            end else if ((cur > tgt) && ((cur - tgt) > step)) begin
                res = cur - step;
            end
        end
        return res;
    endfunction
`endif

    logic tick;
    logic wrap;

    // >= rather than == keeps the prescaler from running away if PRESCALE shrinks mid-count.
    assign tick        = enable_q && (pre_q >= prescale_q);
    assign wrap        = tick && (cnt_q == period_act_q);
    assign period_tick = wrap;
    assign rd_data     = rd_data_q;

    always_comb begin
        enable_d     = enable_q;
        period_stg_d = period_stg_q;
        period_act_d = period_act_q;
        prescale_d   = prescale_q;
        pre_d        = pre_q;
        cnt_d        = cnt_q;
        duty_stg_d   = duty_stg_q;
        duty_act_d   = duty_act_q;
        rd_data_d    = '0;
`ifdef PWM_BANK_RAMP_EN
        ramp_step_d  = ramp_step_q;
`endif

        if (!enable_q) begin
            pre_d        = '0;
            cnt_d        = '0;
            period_act_d = period_stg_q;
            duty_act_d   = duty_stg_q;
        end else begin
            pre_d = tick ? 8'd0 : pre_q + 8'd1;
            if (wrap) begin
                cnt_d        = '0;
                period_act_d = period_stg_q;
                for (int n = 0; n < CHANNELS; n++) begin
`ifdef PWM_BANK_RAMP_EN
                    duty_act_d[n] = rampToward(duty_act_q[n], duty_stg_q[n], ramp_step_q);
`else
                    duty_act_d[n] = duty_stg_q[n];
`endif
                end
            end else if (tick) begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end

        // Writes only touch staged copies, so a wrap in the same cycle still sees the old value.
        if (wr_en) begin
            case (wr_addr)
                ADDR_CTRL:     enable_d     = wr_data[0];
                ADDR_PERIOD:   period_stg_d = wr_data;
                ADDR_PRESCALE: prescale_d   = 8'(wr_data);
`ifdef PWM_BANK_RAMP_EN
                ADDR_RAMP:     ramp_step_d  = wr_data;
`endif
                default: ;
            endcase
            for (int n = 0; n < CHANNELS; n++) begin
                if (wr_addr == (ADDR_DUTY + 8'(n))) duty_stg_d[n] = wr_data;
            end
        end

        case (rd_addr)
            ADDR_CTRL:     rd_data_d = WIDTH'(enable_q);
            ADDR_PERIOD:   rd_data_d = period_stg_q;
            ADDR_PRESCALE: rd_data_d = WIDTH'(prescale_q);
`ifdef PWM_BANK_RAMP_EN
            ADDR_RAMP:     rd_data_d = ramp_step_q;
`endif
            default: ;
        endcase
        for (int n = 0; n < CHANNELS; n++) begin
            if (rd_addr == (ADDR_DUTY + 8'(n))) rd_data_d = duty_stg_q[n];
        end
    end

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            enable_q     <= 1'b0;
            period_stg_q <= '0;
            period_act_q <= '0;
            prescale_q   <= '0;
            pre_q        <= '0;
            cnt_q        <= '0;
            rd_data_q    <= '0;
            duty_stg_q   <= '0;
            duty_act_q   <= '0;
`ifdef PWM_BANK_RAMP_EN
            ramp_step_q  <= '0;
`endif
        end else begin
            enable_q     <= enable_d;
            period_stg_q <= period_stg_d;
            period_act_q <= period_act_d;
            prescale_q   <= prescale_d;
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
            rd_data_q    <= rd_data_d;
            duty_stg_q   <= duty_stg_d;
            duty_act_q   <= duty_act_d;
`ifdef PWM_BANK_RAMP_EN
            ramp_step_q  <= ramp_step_d;
`endif
        end
    end

    // Gating on enable forces the idle level (INVERT) during and after reset, independent of duty.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            pwm_out[n] = (enable_q && (cnt_q < duty_act_q[n])) ^ INVERT[n];
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: scoreboard bench for pwm_bank; a phase-based reference model predicts every cycle's outputs.
// Directed scenarios cover the documented examples, then randomized register traffic runs against the model.
module tb_pwm_bank;

    localparam int              CH        = 4;
    localparam int              W         = 16;
    localparam logic [CH-1:0]   TB_INVERT = 4'b1000;

    logic            SYSCLK;
    logic            NSYSRESET;
    logic            wr_en;
    logic [7:0]      wr_addr;
    logic [W-1:0]    wr_data;
    logic [7:0]      rd_addr;
    logic [W-1:0]    rd_data;
    logic [CH-1:0]   pwm_out;
    logic            period_tick;

    pwm_bank #(.CHANNELS(CH), .WIDTH(W), .INVERT(TB_INVERT)) dut (
        .SYSCLK      (SYSCLK),
        .NSYSRESET   (NSYSRESET),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    typedef struct {
        logic [CH-1:0] pwm;
        logic          tick;
        logic [W-1:0]  rd;
    } expT;

    expT   expQ[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: position inside the period is a raw cycle count (phase); count = phase / (PRESCALE+1).
    bit     mEn;
    int     stgPeriod, actPeriod, mPrescale, mRamp;
    int     stgDuty[CH];
    int     actDuty[CH];
    longint mPhase;
    logic [W-1:0] pendingRd;

    logic [CH-1:0] sampledPwm;
    logic          sampledTick;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic longint periodLen();
        return longint'(actPeriod + 1) * longint'(mPrescale + 1);
    endfunction

    function automatic bit modelTick();
        return mEn && (mPhase == periodLen() - 1);
    endfunction

    function automatic logic [CH-1:0] modelPwm();
        logic [CH-1:0] p;
        longint count;
        count = mPhase / longint'(mPrescale + 1);
        for (int n = 0; n < CH; n++) p[n] = (mEn && (count < longint'(actDuty[n]))) ^ TB_INVERT[n];
        return p;
    endfunction

    function automatic logic [W-1:0] modelRead(input logic [7:0] ra);
        logic [W-1:0] v;
        v = '0;
        if (ra == 8'h00) v = W'(mEn);
        else if (ra == 8'h01) v = W'(stgPeriod);
        else if (ra == 8'h02) v = W'(mPrescale);
`ifdef PWM_BANK_RAMP_EN
        else if (ra == 8'h03) v = W'(mRamp);
`endif
        else if (ra >= 8'h10 && ra < 8'h10 + CH) v = W'(stgDuty[ra - 8'h10]);
        return v;
    endfunction

    function automatic int rampTo(input int cur, input int tgt);
`ifdef PWM_BANK_RAMP_EN
        if (mRamp == 0) return tgt;
        if (tgt > cur) return (tgt - cur <= mRamp) ? tgt : cur + mRamp;
        if (cur > tgt) return (cur - tgt <= mRamp) ? tgt : cur - mRamp;
        return tgt;
`else
        return tgt + (cur - cur);
`endif
    endfunction

    function automatic void modelClock(input bit we, input logic [7:0] wa, input logic [W-1:0] wd);
        if (!mEn) begin
            mPhase    = 0;
            actPeriod = stgPeriod;
            for (int n = 0; n < CH; n++) actDuty[n] = stgDuty[n];
        end else if (modelTick()) begin
            mPhase    = 0;
            actPeriod = stgPeriod;
            for (int n = 0; n < CH; n++) actDuty[n] = rampTo(actDuty[n], stgDuty[n]);
        end else begin
            mPhase++;
        end
        if (we) begin
            if (wa == 8'h00) mEn = wd[0];
            else if (wa == 8'h01) stgPeriod = int'(wd);
            else if (wa == 8'h02) mPrescale = int'(wd & 16'h00FF);
`ifdef PWM_BANK_RAMP_EN
            else if (wa == 8'h03) mRamp = int'(wd);
`endif
            else if (wa >= 8'h10 && wa < 8'h10 + CH) stgDuty[wa - 8'h10] = int'(wd);
        end
    endfunction

    function automatic void modelReset();
        mEn = 0; stgPeriod = 0; actPeriod = 0; mPrescale = 0; mRamp = 0; mPhase = 0;
        for (int n = 0; n < CH; n++) begin
            stgDuty[n] = 0;
            actDuty[n] = 0;
        end
    endfunction

    // One clock cycle: record what the DUT shows now, queue the prediction, drive this cycle's inputs.
    task automatic applyStimulus(input bit we, input logic [7:0] wa, input logic [W-1:0] wd, input logic [7:0] ra);
        expT e;
        @(negedge SYSCLK);
        sampledPwm  = pwm_out;
        sampledTick = period_tick;
        e.pwm  = modelPwm();
        e.tick = modelTick();
        e.rd   = pendingRd;
        expQ.push_back(e);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_addr = ra;
        pendingRd = modelRead(ra);
        modelClock(we, wa, wd);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 8'h00, '0, 8'h10);
    endtask

    // Reset pulse shorter than a clock cycle, landing in the middle of a cycle.
    task automatic resetPulse();
        expT e;
        @(negedge SYSCLK);
        e.pwm  = modelPwm();
        e.tick = modelTick();
        e.rd   = pendingRd;
        expQ.push_back(e);
        wr_en   = 1'b0;
        rd_addr = 8'h10;
        #2 NSYSRESET = 1'b0;
        #1;
        checkOutput("reset_pwm", 32'(pwm_out), 32'(TB_INVERT));
        checkOutput("reset_tick", 32'(period_tick), 32'd0);
        checkOutput("reset_rd", 32'(rd_data), 32'd0);
        #1 NSYSRESET = 1'b1;
        modelReset();
        pendingRd = modelRead(8'h10);
        modelClock(1'b0, 8'h00, '0);
    endtask

    // Monitor: compares every queued prediction against the DUT just after the stimulus edge.
    initial begin
        expT e;
        forever begin
            @(negedge SYSCLK);
            #1;
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pwm_out", 32'(pwm_out), 32'(e.pwm));
                checkOutput("period_tick", 32'(period_tick), 32'(e.tick));
                checkOutput("rd_data", 32'(rd_data), 32'(e.rd));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi[CH];
        int ticks;
        int guard;
        logic [7:0] raList[11];
        bit we;
        logic [7:0] wa;
        logic [W-1:0] wd;
        logic [7:0] ra;

        raList = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h40, 8'hFF};
        modelReset();
        pendingRd = '0;
        NSYSRESET = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;

        repeat (3) @(negedge SYSCLK);
        checkOutput("in_reset_pwm", 32'(pwm_out), 32'(TB_INVERT));
        checkOutput("in_reset_tick", 32'(period_tick), 32'd0);
        checkOutput("in_reset_rd", 32'(rd_data), 32'd0);
        NSYSRESET = 1'b1;

        // PERIOD=9, PRESCALE=0: ch0 duty 3, ch1 duty above period, ch2 zero, ch3 zero but inverted.
        applyStimulus(1'b1, 8'h01, 16'd9, 8'h01);
        applyStimulus(1'b1, 8'h02, 16'd0, 8'h02);
        applyStimulus(1'b1, 8'h10, 16'd3, 8'h10);
        applyStimulus(1'b1, 8'h11, 16'd12, 8'h11);
        applyStimulus(1'b1, 8'h12, 16'd0, 8'h12);
        applyStimulus(1'b1, 8'h13, 16'd0, 8'h13);
        applyStimulus(1'b1, 8'h00, 16'd1, 8'h00);
        ticks = 0;
        for (int n = 0; n < CH; n++) hi[n] = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 8'h00, '0, 8'h10);
            ticks += int'(sampledTick);
            for (int n = 0; n < CH; n++) hi[n] += int'(sampledPwm[n]);
        end
        checkOutput("ch0_high_cycles", 32'(hi[0]), 32'd6);
        checkOutput("tick_count_p9", 32'(ticks), 32'd2);
        checkOutput("ch1_always_high", 32'(hi[1]), 32'd20);
        checkOutput("ch2_always_low", 32'(hi[2]), 32'd0);
        checkOutput("ch3_inverted_high", 32'(hi[3]), 32'd20);

        // Mid-period DUTY write, then a write landing exactly on the wrap cycle.
        guard = 0;
        while (mPhase != 4 && guard < 100) begin idle(1); guard++; end
        checkOutput("mid_period_reached", 32'(guard < 100), 32'd1);
        applyStimulus(1'b1, 8'h10, 16'd7, 8'h10);
        guard = 0;
        while (!modelTick() && guard < 100) begin idle(1); guard++; end
        checkOutput("wrap_reached", 32'(guard < 100), 32'd1);
        applyStimulus(1'b1, 8'h10, 16'd2, 8'h10);
        idle(30);

        // PRESCALE=3, PERIOD=4: one wrap per 20 cycles; unmapped write has no effect.
        applyStimulus(1'b1, 8'h00, 16'd0, 8'h00);
        applyStimulus(1'b1, 8'h02, 16'h1203, 8'h02);
        applyStimulus(1'b1, 8'h01, 16'd4, 8'h02);
        applyStimulus(1'b1, 8'h00, 16'd1, 8'h01);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 8'h00, '0, 8'h10);
            ticks += int'(sampledTick);
        end
        checkOutput("tick_count_ps3", 32'(ticks), 32'd2);
        applyStimulus(1'b1, 8'h40, 16'h0055, 8'h40);
        applyStimulus(1'b0, 8'h00, '0, 8'h40);
        for (int i = 0; i < 11; i++) applyStimulus(1'b0, 8'h00, '0, raList[i]);

`ifdef PWM_BANK_RAMP_EN
        // RAMP_STEP=2 with DUTY0 0 -> 7 should give high times 2, 4, 6, 7 over successive periods.
        applyStimulus(1'b1, 8'h00, 16'd0, 8'h00);
        applyStimulus(1'b1, 8'h02, 16'd0, 8'h02);
        applyStimulus(1'b1, 8'h01, 16'd9, 8'h01);
        applyStimulus(1'b1, 8'h10, 16'd0, 8'h10);
        applyStimulus(1'b1, 8'h03, 16'd2, 8'h03);
        applyStimulus(1'b1, 8'h00, 16'd1, 8'h00);
        applyStimulus(1'b1, 8'h10, 16'd7, 8'h10);
        guard = 0;
        while (!modelTick() && guard < 100) begin idle(1); guard++; end
        idle(1);
        for (int p = 0; p < 4; p++) begin
            hi[0] = 0;
            for (int i = 0; i < 10; i++) begin
                applyStimulus(1'b0, 8'h00, '0, 8'h03);
                hi[0] += int'(sampledPwm[0]);
            end
            checkOutput("ramp_period_high", 32'(hi[0]), (p == 3) ? 32'd7 : 32'(2 * (p + 1)));
        end
`endif

        // Reset in the middle of a channel-0 pulse.
        applyStimulus(1'b1, 8'h00, 16'd0, 8'h00);
        applyStimulus(1'b1, 8'h02, 16'd0, 8'h02);
        applyStimulus(1'b1, 8'h01, 16'd9, 8'h01);
        applyStimulus(1'b1, 8'h10, 16'd7, 8'h10);
        applyStimulus(1'b1, 8'h00, 16'd1, 8'h00);
        idle(3);
        resetPulse();
        for (int i = 0; i < 11; i++) applyStimulus(1'b0, 8'h00, '0, raList[i]);

        // Randomized register traffic; PRESCALE only changes while disabled.
        for (int i = 0; i < 2500; i++) begin
            we = 1'b0; wa = 8'h00; wd = W'($urandom);
            if ($urandom_range(0, 99) < 25) begin
                we = 1'b1;
                case ($urandom_range(0, 6))
                    0: begin wa = 8'h00; wd = (W'($urandom) & 16'hFFFE) | W'($urandom_range(0, 3) != 0); end
                    1: begin wa = 8'h01; wd = W'($urandom_range(0, 12)); end
                    2: begin
                        if (!mEn) begin wa = 8'h02; wd = (W'($urandom) & 16'hFF00) | W'($urandom_range(0, 3)); end
                        else begin wa = 8'h10; wd = W'($urandom_range(0, 14)); end
                    end
                    3: begin wa = 8'h03; wd = W'($urandom_range(0, 4)); end
                    4, 5: begin wa = 8'h10 + 8'($urandom_range(0, CH - 1)); wd = W'($urandom_range(0, 14)); end
                    default: wa = raList[$urandom_range(8, 10)];
                endcase
            end
            ra = raList[$urandom_range(0, 10)];
            applyStimulus(we, wa, wd, ra);
        end

        @(negedge SYSCLK);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
